// File: rtl/vscale_hasti_bridge.sv
// Bridge from the V-Scale core memory port to a single-master HASTI (AHB-Lite) bus.
// Address phase is combinational from the core request; a small register set tracks the data phase.
module vscale_hasti_bridge (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        core_mem_en,
    input  logic        core_mem_wen,
    input  logic [2:0]  core_mem_size,
    input  logic [31:0] core_mem_addr,
    input  logic [31:0] core_mem_wdata_delayed,
    output logic [31:0] core_mem_rdata,
    output logic        core_mem_wait,
    output logic        core_badmem_e,

    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic        hmastlock,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_NOPROT  = 4'b0011;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef struct packed {
        logic valid;
        logic write;
        logic misaligned;
    } dp_t;

    dp_t  dp;
    logic misaligned;
    logic cancel;
    logic ap_go;

    assign hburst    = HBURST_SINGLE;
    assign hmastlock = 1'b0;
    assign hprot     = HPROT_NOPROT;

    assign haddr  = core_mem_addr;
    assign hsize  = core_mem_size;
    assign hwdata = core_mem_wdata_delayed;
    assign core_mem_rdata = hrdata;
    assign core_mem_wait  = ~hready;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        misaligned = 1'b1;
        case (core_mem_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = core_mem_addr[0];
            SIZE_WORD: misaligned = (core_mem_addr[1:0] != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

    // First cycle of a two-cycle ERROR response: the bus must see IDLE here.
    assign cancel = dp.valid & (hresp == HRESP_ERROR) & ~hready;
    assign ap_go  = core_mem_en & ~misaligned & reset_n & ~cancel;

    assign htrans = ap_go ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwrite = ap_go & core_mem_wen;

    // Gated by reset_n so nothing is reported while reset is held, even combinationally.
    assign core_badmem_e = reset_n & ((dp.valid & (hresp == HRESP_ERROR)) | dp.misaligned);

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp <= '0;
        end else if (hready) begin
            dp.valid      <= ap_go;
            dp.write      <= ap_go & core_mem_wen;
            dp.misaligned <= core_mem_en & misaligned;
        end
    end

endmodule

// File: tb/tb_vscale_hasti_bridge.sv
// Directed testbench for vscale_hasti_bridge; each task drives one scenario and checks inline.
module tb_vscale_hasti_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_mem_en;
    logic        core_mem_wen;
    logic [2:0]  core_mem_size;
    logic [31:0] core_mem_addr;
    logic [31:0] core_mem_wdata_delayed;
    logic [31:0] core_mem_rdata;
    logic        core_mem_wait;
    logic        core_badmem_e;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vscale_hasti_bridge dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .core_mem_en            (core_mem_en),
        .core_mem_wen           (core_mem_wen),
        .core_mem_size          (core_mem_size),
        .core_mem_addr          (core_mem_addr),
        .core_mem_wdata_delayed (core_mem_wdata_delayed),
        .core_mem_rdata         (core_mem_rdata),
        .core_mem_wait          (core_mem_wait),
        .core_badmem_e          (core_badmem_e),
        .haddr                  (haddr),
        .hwrite                 (hwrite),
        .hsize                  (hsize),
        .hburst                 (hburst),
        .hmastlock              (hmastlock),
        .hprot                  (hprot),
        .htrans                 (htrans),
        .hwdata                 (hwdata),
        .hrdata                 (hrdata),
        .hready                 (hready),
        .hresp                  (hresp)
    );

    // Advance to 1 time unit past the next rising edge; all driving and checking happens mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic en, input logic wen, input logic [2:0] size,
                             input logic [31:0] addr);
        core_mem_en   = en;
        core_mem_wen  = wen;
        core_mem_size = size;
        core_mem_addr = addr;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_req(1'b1, 1'b1, 3'd2, 32'h100);
        core_mem_wdata_delayed = '0;
        hrdata = '0; hready = 1'b1; hresp = 1'b1;
        #2;
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%0h exp=0", htrans); end
        checks++; if (hwrite !== 1'b0) begin failures++; $display("FAIL reset_hwrite got=%0b exp=0", hwrite); end
        checks++; if (core_badmem_e !== 1'b0) begin failures++; $display("FAIL reset_badmem got=%0b exp=0", core_badmem_e); end
        repeat (2) step();
        drive_req(1'b0, 1'b0, 3'd2, 32'h0);
        hresp = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_idle();
        drive_req(1'b0, 1'b1, 3'd2, 32'hABCD_0010);
        #1;
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL idle_htrans got=%0h exp=0", htrans); end
        checks++; if (hwrite !== 1'b0) begin failures++; $display("FAIL idle_hwrite got=%0b exp=0", hwrite); end
        checks++; if (hburst !== 3'b000) begin failures++; $display("FAIL idle_hburst got=%0h exp=0", hburst); end
        checks++; if (hmastlock !== 1'b0) begin failures++; $display("FAIL idle_hmastlock got=%0b exp=0", hmastlock); end
        checks++; if (hprot !== 4'b0011) begin failures++; $display("FAIL idle_hprot got=%0h exp=3", hprot); end
        checks++; if (haddr !== 32'hABCD_0010) begin failures++; $display("FAIL idle_haddr got=%0h exp=abcd0010", haddr); end
        checks++; if (core_mem_wait !== 1'b0) begin failures++; $display("FAIL idle_wait got=%0b exp=0", core_mem_wait); end
        step();
        checks++; if (core_badmem_e !== 1'b0) begin failures++; $display("FAIL idle_badmem got=%0b exp=0", core_badmem_e); end
    endtask

    task automatic test_read();
        drive_req(1'b1, 1'b0, 3'd2, 32'h100);
        hready = 1'b1;
        #1;
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL read_htrans got=%0h exp=2", htrans); end
        checks++; if (hwrite !== 1'b0) begin failures++; $display("FAIL read_hwrite got=%0b exp=0", hwrite); end
        checks++; if (haddr !== 32'h100) begin failures++; $display("FAIL read_haddr got=%0h exp=100", haddr); end
        checks++; if (hsize !== 3'd2) begin failures++; $display("FAIL read_hsize got=%0d exp=2", hsize); end
        step();
        drive_req(1'b0, 1'b0, 3'd2, 32'h0);
        hrdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (core_mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_rdata got=%0h exp=deadbeef", core_mem_rdata); end
        checks++; if (core_badmem_e !== 1'b0) begin failures++; $display("FAIL read_badmem got=%0b exp=0", core_badmem_e); end
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL read_dp_htrans got=%0h exp=0", htrans); end
        step();
    endtask

    // First write stalls one cycle while the second is held on the bus, then both complete pipelined.
    task automatic test_write_wait();
        drive_req(1'b1, 1'b1, 3'd2, 32'h200);
        hready = 1'b1;
        #1;
        checks++; if (hwrite !== 1'b1) begin failures++; $display("FAIL wr_hwrite got=%0b exp=1", hwrite); end
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL wr_htrans got=%0h exp=2", htrans); end
        step();
        drive_req(1'b1, 1'b1, 3'd2, 32'h204);
        core_mem_wdata_delayed = 32'h1234_5678;
        hready = 1'b0;
        #1;
        checks++; if (core_mem_wait !== 1'b1) begin failures++; $display("FAIL wr_stall_wait got=%0b exp=1", core_mem_wait); end
        checks++; if (hwdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_stall_hwdata got=%0h exp=12345678", hwdata); end
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL wr_stall_htrans got=%0h exp=2", htrans); end
        checks++; if (hwrite !== 1'b1) begin failures++; $display("FAIL wr_stall_hwrite got=%0b exp=1", hwrite); end
        checks++; if (haddr !== 32'h204) begin failures++; $display("FAIL wr_stall_haddr got=%0h exp=204", haddr); end
        step();
        hready = 1'b1;
        #1;
        checks++; if (core_mem_wait !== 1'b0) begin failures++; $display("FAIL wr_done_wait got=%0b exp=0", core_mem_wait); end
        checks++; if (hwdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_done_hwdata got=%0h exp=12345678", hwdata); end
        checks++; if (core_badmem_e !== 1'b0) begin failures++; $display("FAIL wr_done_badmem got=%0b exp=0", core_badmem_e); end
        step();
        drive_req(1'b0, 1'b0, 3'd2, 32'h0);
        core_mem_wdata_delayed = 32'hCAFE_F00D;
        #1;
        checks++; if (hwdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL wr2_hwdata got=%0h exp=cafef00d", hwdata); end
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL wr2_htrans got=%0h exp=0", htrans); end
        step();
    endtask

    task automatic test_alignment();
        hready = 1'b1;
        drive_req(1'b1, 1'b0, 3'd1, 32'h101);
        #1;
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL align_half_odd got=%0h exp=0", htrans); end
        drive_req(1'b1, 1'b0, 3'd1, 32'h102);
        #1;
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL align_half_even got=%0h exp=2", htrans); end
        drive_req(1'b1, 1'b0, 3'd0, 32'h103);
        #1;
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL align_byte got=%0h exp=2", htrans); end
        drive_req(1'b1, 1'b1, 3'd3, 32'h100);
        #1;
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL align_size3 got=%0h exp=0", htrans); end
        checks++; if (hwrite !== 1'b0) begin failures++; $display("FAIL align_size3_hwrite got=%0b exp=0", hwrite); end
        drive_req(1'b1, 1'b1, 3'd2, 32'h102);
        #1;
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL mis_htrans got=%0h exp=0", htrans); end
        checks++; if (hwrite !== 1'b0) begin failures++; $display("FAIL mis_hwrite got=%0b exp=0", hwrite); end
        step();
        drive_req(1'b0, 1'b0, 3'd2, 32'h0);
        #1;
        checks++; if (core_badmem_e !== 1'b1) begin failures++; $display("FAIL mis_badmem got=%0b exp=1", core_badmem_e); end
        step();
        checks++; if (core_badmem_e !== 1'b0) begin failures++; $display("FAIL mis_badmem_clear got=%0b exp=0", core_badmem_e); end
    endtask

    task automatic test_error();
        hready = 1'b1; hresp = 1'b0;
        drive_req(1'b1, 1'b0, 3'd2, 32'h300);
        step();
        drive_req(1'b1, 1'b0, 3'd2, 32'h304);
        hresp = 1'b1; hready = 1'b0;
        #1;
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL err1_htrans got=%0h exp=0", htrans); end
        checks++; if (hwrite !== 1'b0) begin failures++; $display("FAIL err1_hwrite got=%0b exp=0", hwrite); end
        checks++; if (core_badmem_e !== 1'b1) begin failures++; $display("FAIL err1_badmem got=%0b exp=1", core_badmem_e); end
        step();
        hready = 1'b1;
        #1;
        checks++; if (core_badmem_e !== 1'b1) begin failures++; $display("FAIL err2_badmem got=%0b exp=1", core_badmem_e); end
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL err2_htrans got=%0h exp=2", htrans); end
        drive_req(1'b0, 1'b0, 3'd2, 32'h0);
        step();
        hresp = 1'b0;
        #1;
        checks++; if (core_badmem_e !== 1'b0) begin failures++; $display("FAIL err_after_badmem got=%0b exp=0", core_badmem_e); end
        step();
    endtask

    task automatic test_reset_mid();
        hready = 1'b1; hresp = 1'b0;
        drive_req(1'b1, 1'b0, 3'd2, 32'h400);
        step();
        hresp = 1'b1;
        #1;
        checks++; if (core_badmem_e !== 1'b1) begin failures++; $display("FAIL rst_pre_badmem got=%0b exp=1", core_badmem_e); end
        reset_n = 1'b0;
        #1;
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL rst_mid_htrans got=%0h exp=0", htrans); end
        checks++; if (core_badmem_e !== 1'b0) begin failures++; $display("FAIL rst_mid_badmem got=%0b exp=0", core_badmem_e); end
        step();
        hresp = 1'b0;
        drive_req(1'b1, 1'b0, 3'd2, 32'h0);
        reset_n = 1'b1;
        #1;
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL rst_first_htrans got=%0h exp=2", htrans); end
        checks++; if (haddr !== 32'h0) begin failures++; $display("FAIL rst_first_haddr got=%0h exp=0", haddr); end
        step();
        drive_req(1'b0, 1'b0, 3'd2, 32'h0);
        hrdata = 32'h0BAD_F00D;
        #1;
        checks++; if (core_mem_rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL rst_first_rdata got=%0h exp=badf00d", core_mem_rdata); end
        checks++; if (core_badmem_e !== 1'b0) begin failures++; $display("FAIL rst_first_badmem got=%0b exp=0", core_badmem_e); end
        step();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_read();
        test_write_wait();
        test_alignment();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vscale_hasti_bridge.md
VSCALE_HASTI_BRIDGE -- requirements
Module: vscale_hasti_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, as listed below.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
REQ-002 The core-side ports SHALL be:
- core_mem_en  in  1  access request
- core_mem_wen  in  1  write when 1
- core_mem_size  in  3  HSIZE encoding: 0 byte, 1 half, 2 word
- core_mem_addr  in  32  access address
- core_mem_wdata_delayed  in  32  write data, presented one cycle after its address (data phase)
- core_mem_rdata  out  32  read data
- core_mem_wait  out  1  stall
- core_badmem_e  out  1  access error
REQ-003 The HASTI (AHB-Lite master) ports SHALL be:
- haddr  out  32
- hwrite  out  1
- hsize  out  3
- hburst  out  3
- hmastlock  out  1
- hprot  out  4
- htrans  out  2
- hwdata  out  32
- hrdata  in  32
- hready  in  1
- hresp  in  1

Function
REQ-004 Encodings SHALL be:
- HTRANS IDLE=2'b00, NONSEQ=2'b10.
- HBURST SINGLE=3'b000.
- HPROT NOPROT=4'b0011.
- HRESP OKAY=0, ERROR=1.
REQ-005 The static outputs SHALL be hburst=SINGLE, hmastlock=0 and hprot=NOPROT at all times.
REQ-006 haddr SHALL equal core_mem_addr and hsize SHALL equal core_mem_size, combinationally.
REQ-007 An address is misaligned when:
- size is half and addr[0]=1, or
- size is word and addr[1:0]!=0.
Sizes above 2 SHALL be treated as misaligned.
REQ-008 An address phase is issued (ap_go) only when all of the following hold:
- core_mem_en=1,
- the address is aligned,
- reset_n=1,
- no error cancel is active (REQ-013).
REQ-009 When ap_go=1, htrans SHALL be NONSEQ; otherwise htrans SHALL be IDLE.
REQ-010 hwrite SHALL equal ap_go & core_mem_wen.
REQ-011 Data-phase registers dp_valid, dp_write and dp_misaligned SHALL update on every rising clk edge where hready=1:
- dp_valid <= ap_go
- dp_write <= ap_go & core_mem_wen
- dp_misaligned <= core_mem_en & misaligned
When hready=0 the registers SHALL hold their values.
REQ-012 The data path SHALL be pass-through:
- hwdata = core_mem_wdata_delayed
- core_mem_rdata = hrdata
There is zero added latency: read data is valid in the cycle after the address phase, when hready=1.
REQ-013 If dp_valid=1, hresp=ERROR and hready=0 (first cycle of the two-cycle error response), htrans SHALL be forced to IDLE and hwrite to 0 in that cycle (cancel). This cycle does not cause a data-phase register capture, because hready=0.
REQ-014 core_badmem_e SHALL be 1 when either:
- dp_valid=1 and hresp=ERROR, or
- dp_misaligned=1.
It is 0 otherwise.
REQ-015 core_mem_wait SHALL equal ~hready, independent of core_mem_en.
REQ-016 A misaligned request SHALL NOT reach the bus. It still advances the data phase, so core_badmem_e pulses for exactly one hready=1 cycle following it.
REQ-017 Back-to-back requests SHALL be pipelined: a new address phase is issued in the same cycle as the previous data phase.

Reset
REQ-018 While reset_n=0, all data-phase registers SHALL be cleared asynchronously.
REQ-019 While reset_n=0, htrans SHALL be IDLE, hwrite 0 and core_badmem_e 0.
REQ-020 A reset asserted during an outstanding data phase SHALL abandon that phase with no error report.
REQ-021 After reset_n rises, the first request SHALL be issued in the same cycle it is presented.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Aligned word read: en=1, wen=0, size=2, addr=0x100, hready=1 -> htrans=NONSEQ, hwrite=0, haddr=0x100; next cycle hrdata=0xDEADBEEF -> core_mem_rdata=0xDEADBEEF, badmem_e=0.
- Word write with wait state: en=1, wen=1, addr=0x200, then hready=0 for one cycle -> hwrite=1, htrans=NONSEQ, wait=1 during the stall; hwdata equals wdata_delayed=0x12345678 during the data phase.
- Misaligned: en=1, size=2, addr=0x102 -> htrans=IDLE; next cycle badmem_e=1, then 0.
- Error response: data phase with hresp=1, hready=0, then hresp=1, hready=1 -> first cycle htrans=IDLE and badmem_e=1; second cycle badmem_e=1.
- Reset mid-transaction: reset_n=0 during a data phase -> htrans=IDLE and badmem_e=0 immediately; after release a read to 0x0 is issued the same cycle.
- Idle: en=0 -> htrans=IDLE, hwrite=0; static outputs hburst=0, hmastlock=0, hprot=4'b0011.
